// File: rtl/wb_scoreboard_if.sv
// Writeback scoreboard bus: expected-record push channel plus the tapped DUT writeback ports.
interface wb_scoreboard_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 36,
  parameter int REG_W  = 5,
  parameter int PC_W   = 36
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                     exp_valid;
  logic                     exp_ready;
  logic [CH_W-1:0]          exp_ch;
  logic [PC_W-1:0]          exp_pc;
  logic [REG_W-1:0]         exp_reg;
  logic [DATA_W-1:0]        exp_data;
  logic [DATA_W-1:0]        exp_mask;
  logic [NUM_CH-1:0]        act_valid;
  logic [NUM_CH*REG_W-1:0]  act_reg;
  logic [NUM_CH*DATA_W-1:0] act_data;

  modport master (
    output exp_valid, exp_ch, exp_pc, exp_reg, exp_data, exp_mask,
    output act_valid, act_reg, act_data,
    input  exp_ready
  );

  modport slave (
    input  exp_valid, exp_ch, exp_pc, exp_reg, exp_data, exp_mask,
    input  act_valid, act_reg, act_data,
    output exp_ready
  );
endinterface

// File: rtl/wb_scoreboard.sv
// Multi-channel in-order writeback scoreboard with per-bit compare masks.
// Optional stall detector enabled by defining WB_SB_TIMEOUT_EN.
module wb_sb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;

  // Extra pointer bit tells full from empty when the index bits coincide.
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end
endmodule

module wb_scoreboard #(
  parameter int NUM_CH      = 2,
  parameter int DATA_W      = 36,
  parameter int REG_W       = 5,
  parameter int PC_W        = 36,
  parameter int DEPTH       = 8,
  parameter int HALT_ON_ERR = 1,
  parameter int TIMEOUT     = 1024,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_scoreboard_if.slave    sb,
  output logic              err_flag,
  output logic [1:0]        err_code,
  output logic [CH_W-1:0]   err_ch,
  output logic [PC_W-1:0]   err_pc,
  output logic [REG_W-1:0]  err_exp_reg,
  output logic [REG_W-1:0]  err_act_reg,
  output logic [DATA_W-1:0] err_exp_data,
  output logic [DATA_W-1:0] err_act_data,
  output logic [31:0]       match_cnt,
  output logic [15:0]       err_cnt,
  output logic [NUM_CH-1:0] pending
);
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [REG_W-1:0]  rg;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] mask;
  } rec_t;

  typedef enum logic {RUN, HALT} state_t;

  state_t              state_q, state_d;
  logic                run;
  rec_t                rec_in;
  rec_t [NUM_CH-1:0]   head;
  logic [NUM_CH-1:0]   full, empty, push, pop, ok, bad;
  logic                sel_full;
  logic [2:0]          n_ok, n_bad;
  logic [16:0]         err_sum;
  logic                to_hit;
  logic                cap_vld;
  logic [1:0]          cap_code;
  logic [CH_W-1:0]     cap_ch;
  logic [PC_W-1:0]     cap_pc;
  logic [REG_W-1:0]    cap_ereg, cap_areg;
  logic [DATA_W-1:0]   cap_edata, cap_adata;

  assign run     = (state_q == RUN);
  assign rec_in  = '{pc: sb.exp_pc, rg: sb.exp_reg, data: sb.exp_data, mask: sb.exp_mask};
  assign pending = ~empty;

  // Out-of-range channel selects read as full so they are never accepted.
  always_comb begin
    sel_full = 1'b1;
    for (int c = 0; c < NUM_CH; c++)
      if (sb.exp_ch == CH_W'(c)) sel_full = full[c];
  end

  assign sb.exp_ready = run && !sel_full;

  always_comb begin
    push = '0;
    for (int c = 0; c < NUM_CH; c++)
      push[c] = sb.exp_valid && sb.exp_ready && (sb.exp_ch == CH_W'(c));
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    wb_sb_fifo #(.W($bits(rec_t)), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[c]),
      .pop   (pop[c]),
      .din   (rec_in),
      .head  (head[c]),
      .full  (full[c]),
      .empty (empty[c])
    );
  end

  always_comb begin
    pop   = '0;
    ok    = '0;
    bad   = '0;
    n_ok  = '0;
    n_bad = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (run && sb.act_valid[c]) begin
        if (empty[c]) begin
          bad[c] = 1'b1;
        end else begin
          pop[c] = 1'b1;
          if (sb.act_reg[c*REG_W +: REG_W] == head[c].rg &&
              ((sb.act_data[c*DATA_W +: DATA_W] ^ head[c].data) & head[c].mask) == '0)
            ok[c] = 1'b1;
          else
            bad[c] = 1'b1;
        end
      end
      n_ok  = n_ok  + {2'b00, ok[c]};
      n_bad = n_bad + {2'b00, bad[c]};
    end
  end

`ifdef WB_SB_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic        idle;

  assign idle   = run && (|pending) && !(|sb.act_valid);
  assign to_hit = idle && (idle_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              idle_cnt <= '0;
    else if (run) begin
      if (!idle || to_hit)   idle_cnt <= '0;
      else                   idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // Walk high to low so the lowest-numbered erroring channel wins.
  always_comb begin
    cap_vld   = 1'b0;
    cap_code  = 2'd0;
    cap_ch    = '0;
    cap_pc    = '0;
    cap_ereg  = '0;
    cap_areg  = '0;
    cap_edata = '0;
    cap_adata = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (bad[c]) begin
        cap_vld   = 1'b1;
        cap_ch    = CH_W'(c);
        cap_code  = empty[c] ? 2'd2 : 2'd1;
        cap_pc    = empty[c] ? '0 : head[c].pc;
        cap_ereg  = empty[c] ? '0 : head[c].rg;
        cap_edata = empty[c] ? '0 : head[c].data;
        cap_areg  = sb.act_reg[c*REG_W +: REG_W];
        cap_adata = sb.act_data[c*DATA_W +: DATA_W];
      end
    end
`ifdef WB_SB_TIMEOUT_EN
    if (!cap_vld && to_hit) begin
      cap_vld  = 1'b1;
      cap_code = 2'd3;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (!empty[c]) begin
          cap_ch    = CH_W'(c);
          cap_pc    = head[c].pc;
          cap_ereg  = head[c].rg;
          cap_edata = head[c].data;
        end
      end
    end
`endif
  end

  assign err_sum = {1'b0, err_cnt} + 17'(n_bad) + 17'(to_hit);

  always_comb begin
    state_d = state_q;
    if (run && cap_vld && HALT_ON_ERR != 0) state_d = HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag     <= 1'b0;
      err_code     <= 2'd0;
      err_ch       <= '0;
      err_pc       <= '0;
      err_exp_reg  <= '0;
      err_act_reg  <= '0;
      err_exp_data <= '0;
      err_act_data <= '0;
      match_cnt    <= '0;
      err_cnt      <= '0;
    end else if (run) begin
      match_cnt <= match_cnt + 32'(n_ok);
      err_cnt   <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (!err_flag && cap_vld) begin
        err_flag     <= 1'b1;
        err_code     <= cap_code;
        err_ch       <= cap_ch;
        err_pc       <= cap_pc;
        err_exp_reg  <= cap_ereg;
        err_act_reg  <= cap_areg;
        err_exp_data <= cap_edata;
        err_act_data <= cap_adata;
      end
    end
  end
endmodule

// File: tb/tb_wb_scoreboard.sv
// Bench for wb_scoreboard: directed table, corner sequences, and randomized run vs a queue model.
module tb_wb_scoreboard;
  localparam int NUM_CH = 2, DATA_W = 36, REG_W = 5, PC_W = 36, DEPTH = 8, TIMEOUT = 16;
  localparam logic [35:0] ONES = '1;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_scoreboard_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .REG_W(REG_W), .PC_W(PC_W)) sb();

  logic        err_flag;
  logic [1:0]  err_code;
  logic [0:0]  err_ch;
  logic [35:0] err_pc, err_exp_data, err_act_data;
  logic [4:0]  err_exp_reg, err_act_reg;
  logic [31:0] match_cnt;
  logic [15:0] err_cnt;
  logic [1:0]  pending;

  wb_scoreboard #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .REG_W(REG_W), .PC_W(PC_W),
                  .DEPTH(DEPTH), .HALT_ON_ERR(1), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .sb(sb),
    .err_flag(err_flag), .err_code(err_code), .err_ch(err_ch), .err_pc(err_pc),
    .err_exp_reg(err_exp_reg), .err_act_reg(err_act_reg),
    .err_exp_data(err_exp_data), .err_act_data(err_act_data),
    .match_cnt(match_cnt), .err_cnt(err_cnt), .pending(pending)
  );

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model: one queue per channel ----------------
  typedef struct {
    logic [35:0] pc;
    logic [4:0]  rg;
    logic [35:0] data;
    logic [35:0] mask;
  } rec_t;

  rec_t        mq [NUM_CH][$];
  bit          m_halt, m_flag;
  logic [1:0]  m_code;
  logic [0:0]  m_ch;
  logic [35:0] m_pc;
  logic [31:0] m_match;
  int          m_errc, m_idle;

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    m_halt = 0; m_flag = 0; m_code = 0; m_ch = 0; m_pc = 0;
    m_match = 0; m_errc = 0; m_idle = 0;
  endtask

  // Applies one clock edge worth of the rules to the model, using the inputs present now.
  task automatic model_edge();
    int ne = 0;
    bit cap = 0, acc, anyp;
    logic [1:0] c_code = 0;
    logic [0:0] c_ch = 0;
    logic [35:0] c_pc = 0;
    rec_t r, nr;
    if (m_halt) return;
    acc  = sb.exp_valid && (mq[sb.exp_ch].size() < DEPTH);
    anyp = (mq[0].size() != 0) || (mq[1].size() != 0);
    for (int c = 0; c < NUM_CH; c++) begin
      if (sb.act_valid[c]) begin
        if (mq[c].size() == 0) begin
          ne++;
          if (!cap) begin cap = 1; c_code = 2; c_ch = 1'(c); c_pc = 0; end
        end else begin
          r = mq[c].pop_front();
          if (sb.act_reg[c*5 +: 5] == r.rg && ((sb.act_data[c*36 +: 36] ^ r.data) & r.mask) == 0)
            m_match++;
          else begin
            ne++;
            if (!cap) begin cap = 1; c_code = 1; c_ch = 1'(c); c_pc = r.pc; end
          end
        end
      end
    end
`ifdef WB_SB_TIMEOUT_EN
    if (sb.act_valid != 0 || !anyp) m_idle = 0;
    else begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_idle = 0;
        ne++;
        if (!cap) begin
          cap = 1; c_code = 3;
          c_ch = (mq[0].size() != 0) ? 1'b0 : 1'b1;
          c_pc = mq[c_ch][0].pc;
        end
      end
    end
`else
    if (anyp) m_idle = 0;
`endif
    if (acc) begin
      nr.pc = sb.exp_pc; nr.rg = sb.exp_reg; nr.data = sb.exp_data; nr.mask = sb.exp_mask;
      mq[sb.exp_ch].push_back(nr);
    end
    m_errc = (m_errc + ne > 65535) ? 65535 : m_errc + ne;
    if (cap && !m_flag) begin m_flag = 1; m_code = c_code; m_ch = c_ch; m_pc = c_pc; end
    if (cap) m_halt = 1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clr_in();
    sb.exp_valid = 0; sb.exp_ch = 0; sb.exp_pc = 0; sb.exp_reg = 0;
    sb.exp_data = 0; sb.exp_mask = 0; sb.act_valid = 0; sb.act_reg = 0; sb.act_data = 0;
  endtask

  task automatic set_in(input logic ev, input logic ch, input logic [35:0] pc, input logic [4:0] rg,
                        input logic [35:0] dat, input logic [35:0] msk, input logic [1:0] av,
                        input logic [9:0] ar, input logic [71:0] ad);
    sb.exp_valid = ev; sb.exp_ch = ch; sb.exp_pc = pc; sb.exp_reg = rg;
    sb.exp_data = dat; sb.exp_mask = msk; sb.act_valid = av; sb.act_reg = ar; sb.act_data = ad;
  endtask

  task automatic cyc(input logic ev, input logic ch, input logic [35:0] pc, input logic [4:0] rg,
                     input logic [35:0] dat, input logic [1:0] av, input logic [9:0] ar,
                     input logic [71:0] ad);
    @(negedge clk);
    set_in(ev, ch, pc, rg, dat, ONES, av, ar, ad);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; clr_in();
    @(negedge clk);
    rst_n = 1;
    model_clear();
  endtask

  task automatic rand_inputs();
    logic [63:0] r;
    rec_t h;
    logic [4:0] rg;
    logic [35:0] d;
    bit av;
    sb.exp_valid = ($urandom_range(99) < 55);
    sb.exp_ch    = 1'($urandom_range(1));
    r = {$urandom(), $urandom()}; sb.exp_data = r[35:0];
    r = {$urandom(), $urandom()}; sb.exp_mask = ($urandom_range(1) == 1) ? ONES : r[35:0];
    r = {$urandom(), $urandom()}; sb.exp_pc = r[35:0];
    sb.exp_reg = 5'($urandom());
    for (int c = 0; c < NUM_CH; c++) begin
      av = ($urandom_range(99) < 40);
      r  = {$urandom(), $urandom()};
      if (mq[c].size() != 0) begin
        h  = mq[c][0];
        rg = h.rg;
        d  = h.data ^ (r[35:0] & ~h.mask);
        if ($urandom_range(99) < 1) rg = rg ^ 5'd1;
      end else begin
        av = av && ($urandom_range(99) < 5);
        rg = 5'($urandom());
        d  = r[35:0];
      end
      sb.act_valid[c] = av;
      sb.act_reg[c*5 +: 5] = rg;
      sb.act_data[c*36 +: 36] = d;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic ev; logic ch; logic [35:0] pc; logic [4:0] rg; logic [35:0] dat, msk;
    logic [1:0] av; logic [9:0] ar; logic [71:0] ad;
    logic [31:0] x_match; logic [15:0] x_errc; logic [1:0] x_code, x_pend; logic x_rdy;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 36'h100, 5'd3, 36'h5, ONES, 2'b00, 10'h0, 72'h0,
               32'd0, 16'd0, 2'd0, 2'b01, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 36'h0, 5'd0, 36'h0, 36'h0, 2'b01, {5'd0, 5'd3}, {36'h0, 36'h5},
               32'd1, 16'd0, 2'd0, 2'b00, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 36'h104, 5'd4, 36'h000012345, 36'h00003FFFF, 2'b00, 10'h0, 72'h0,
               32'd1, 16'd0, 2'd0, 2'b01, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 36'h0, 5'd0, 36'h0, 36'h0, 2'b01, {5'd0, 5'd4}, {36'h0, 36'hFFFC12345},
               32'd2, 16'd0, 2'd0, 2'b00, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 36'h108, 5'd1, 36'h11, ONES, 2'b00, 10'h0, 72'h0,
               32'd2, 16'd0, 2'd0, 2'b01, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 36'h200, 5'd7, 36'hA, ONES, 2'b00, 10'h0, 72'h0,
               32'd2, 16'd0, 2'd0, 2'b11, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 36'h0, 5'd0, 36'h0, 36'h0, 2'b11, {5'd7, 5'd1}, {36'hB, 36'h11},
               32'd3, 16'd1, 2'd1, 2'b00, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 36'h300, 5'd2, 36'h1, ONES, 2'b10, {5'd7, 5'd0}, {36'hB, 36'h0},
               32'd3, 16'd1, 2'd1, 2'b00, 1'b0};

    clr_in();
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_err_flag", err_flag, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_match_cnt", match_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_pending", pending, 0);
    chk("rst_exp_ready", sb.exp_ready, 1);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_in(tbl[i].ev, tbl[i].ch, tbl[i].pc, tbl[i].rg, tbl[i].dat, tbl[i].msk,
             tbl[i].av, tbl[i].ar, tbl[i].ad);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_match_cnt", i), match_cnt, tbl[i].x_match);
      chk($sformatf("tbl%0d_err_cnt", i), err_cnt, tbl[i].x_errc);
      chk($sformatf("tbl%0d_err_code", i), err_code, tbl[i].x_code);
      chk($sformatf("tbl%0d_pending", i), pending, tbl[i].x_pend);
      chk($sformatf("tbl%0d_exp_ready", i), sb.exp_ready, tbl[i].x_rdy);
    end
    chk("mm_err_flag", err_flag, 1);
    chk("mm_err_ch", err_ch, 1);
    chk("mm_err_pc", err_pc, 36'h200);
    chk("mm_err_exp_reg", err_exp_reg, 7);
    chk("mm_err_act_reg", err_act_reg, 7);
    chk("mm_err_exp_data", err_exp_data, 36'hA);
    chk("mm_err_act_data", err_act_data, 36'hB);

    // Asynchronous reset in the middle of a cycle, no clock edge involved.
    #1 rst_n = 0; clr_in();
    #1;
    chk("arst_match_cnt", match_cnt, 0);
    chk("arst_err_flag", err_flag, 0);
    chk("arst_err_code", err_code, 0);
    chk("arst_err_cnt", err_cnt, 0);
    chk("arst_err_pc", err_pc, 0);
    chk("arst_exp_ready", sb.exp_ready, 1);
    @(negedge clk);
    rst_n = 1;

    // Underflow on an empty channel.
    do_reset();
    cyc(0, 0, 0, 0, 0, 2'b01, 10'h0, 72'h0);
    chk("uf_err_code", err_code, 2);
    chk("uf_err_cnt", err_cnt, 1);
    chk("uf_err_ch", err_ch, 0);
    chk("uf_pending", pending, 0);

    // Push and actual on the same empty channel: underflow, record still enqueued.
    do_reset();
    cyc(1, 1, 36'h40, 5'd2, 36'h3, 2'b10, {5'd2, 5'd0}, {36'h3, 36'h0});
    chk("ufp_err_code", err_code, 2);
    chk("ufp_err_ch", err_ch, 1);
    chk("ufp_pending", pending, 2'b10);

    // Fill channel 0, then push+pop on the full channel: push refused, pop compared.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 36'(i), 5'(i), 36'(i), 2'b00, 10'h0, 72'h0);
    @(negedge clk);
    clr_in(); #1;
    chk("full_exp_ready", sb.exp_ready, 0);
    chk("full_pending", pending, 2'b01);
    sb.exp_ch = 1; #1;
    chk("full_other_ch_ready", sb.exp_ready, 1);
    set_in(1, 0, 36'h999, 5'd0, 36'h99, ONES, 2'b01, 10'h0, 72'h0); #1;
    chk("full_pushpop_ready", sb.exp_ready, 0);
    @(posedge clk); #1;
    chk("full_pop_match", match_cnt, 1);
    for (int i = 1; i < DEPTH; i++) cyc(0, 0, 0, 0, 0, 2'b01, {5'd0, 5'(i)}, {36'h0, 36'(i)});
    chk("drain_match", match_cnt, DEPTH);
    chk("drain_err_flag", err_flag, 0);
    cyc(0, 0, 0, 0, 0, 2'b01, 10'h0, {36'h0, 36'h99});
    chk("refused_push_underflow", err_code, 2);

    // Stall detection (or its absence in the default build).
    do_reset();
    cyc(1, 1, 36'h500, 5'd9, 36'h1, 2'b00, 10'h0, 72'h0);
`ifdef WB_SB_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT - 1; i++) cyc(0, 0, 0, 0, 0, 2'b00, 10'h0, 72'h0);
    chk("to_before_flag", err_flag, 0);
    cyc(0, 0, 0, 0, 0, 2'b00, 10'h0, 72'h0);
    chk("to_err_flag", err_flag, 1);
    chk("to_err_code", err_code, 3);
    chk("to_err_ch", err_ch, 1);
    chk("to_err_pc", err_pc, 36'h500);
    chk("to_err_act_data", err_act_data, 0);
`else
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0, 0, 2'b00, 10'h0, 72'h0);
    chk("noto_err_flag", err_flag, 0);
    chk("noto_pending", pending, 2'b10);
`endif

    // Randomized episodes against the queue model.
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int n = 0; n < 250 && !m_halt; n++) begin
        @(negedge clk);
        rand_inputs(); #1;
        chk("rnd_exp_ready", sb.exp_ready, !m_halt && (mq[sb.exp_ch].size() < DEPTH));
        @(posedge clk);
        model_edge();
        #1;
        chk("rnd_match_cnt", match_cnt, m_match);
        chk("rnd_err_cnt", err_cnt, 16'(m_errc));
        chk("rnd_err_flag", err_flag, m_flag);
        chk("rnd_err_code", err_code, m_code);
        chk("rnd_err_ch", err_ch, m_ch);
        chk("rnd_err_pc", err_pc, m_pc);
        chk("rnd_pending", pending, {mq[1].size() != 0, mq[0].size() != 0});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_scoreboard.md
# wb_scoreboard

Synthesizable, parametrised writeback scoreboard that checks a processor's writeback streams against expected records from a trace, in program order. It generalises our single scalar-writeback compare to NUM_CH independent channels (e.g. scalar and vector writeback). Each channel has its own expected-record FIFO, and each record can carry a per-bit compare mask for partial-write instructions such as `lil`. It sits beside `proc` in the bench and is also synthesizable for on-FPGA self-check. A bench-side trace reader pushes records into it, and it taps the DUT writeback ports directly.

## Interface
- NUM_CH, 2, number of writeback channels (1..4)
- DATA_W, 36, writeback data width
- REG_W, 5, register index width
- PC_W, 36, PC width
- DEPTH, 8, expected-record FIFO depth per channel (power of two, ≥2)
- HALT_ON_ERR, 1, 1 = enter HALT on first error; 0 = keep checking
- TIMEOUT, 1024, stall-detect cycle limit (only with WB_SB_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- exp_valid  in  1  expected record offered
- exp_ready  out  1  record accepted when exp_valid && exp_ready
- exp_ch  in  $clog2(NUM_CH) (min 1)  target channel
- exp_pc  in  PC_W  PC of the instruction
- exp_reg  in  REG_W  expected destination register
- exp_data  in  DATA_W  expected writeback value
- exp_mask  in  DATA_W  compare mask (1 = bit checked)
- act_valid  in  NUM_CH  DUT writeback strobe, one bit per channel
- act_reg  in  NUM_CH*REG_W  DUT destination registers, channel c at [c*REG_W +: REG_W]
- act_data  in  NUM_CH*DATA_W  DUT writeback data, packed the same way
- err_flag  out  1  sticky; set on first error
- err_code  out  2  0 none, 1 mismatch, 2 underflow, 3 timeout
- err_ch, err_pc, err_exp_reg, err_act_reg, err_exp_data, err_act_data  out  widths as above  details of the first error, then frozen
- match_cnt  out  32  total matched writebacks
- err_cnt  out  16  total errors, saturates at 16'hFFFF
- pending  out  NUM_CH  channel FIFO non-empty

## Operation
- Each channel FIFO stores {pc, reg, data, mask}. Push happens on the channel selected by exp_ch.
- exp_ready = !full[exp_ch] && state==RUN.
- When act_valid[c] is high and FIFO c is non-empty, the head is popped and compared.
  - Match: act_reg==head.reg and ((act_data ^ head.data) & head.mask)==0. On a match, match_cnt increments.
  - Otherwise: mismatch (code 1).
- When act_valid[c] is high and FIFO c is empty: underflow (code 2). Nothing is popped.
- Multiple channels can strobe in the same cycle. All are checked. match_cnt and err_cnt add the number of matches and errors that cycle. If the error detail is being captured that cycle, the lowest-numbered erroring channel is reported.
- Error details are captured only while err_flag==0.
- States:
  - RUN: normal operation.
  - HALT: entered on the first error when HALT_ON_ERR=1. In HALT, pushes are blocked, act_valid is ignored, and counters hold.
  - HALT is left only by reset.
- A push and a pop on the same channel in the same cycle are both performed. When full, exp_ready=0 even if a pop occurs that cycle; there is no pass-through.
- Push and actual on an empty channel in the same cycle: no bypass. The actual is an underflow, and the record is enqueued.
- Pointers are log2(DEPTH)+1 bits. They wrap modulo 2·DEPTH; full and empty are decided by MSB comparison.

## Timing
- Comparison is combinational on the FIFO head. Counters, err_* fields and state are registered, so they update at the edge that samples act_valid and are visible the next cycle.
- A pushed record becomes the head one cycle after the push edge.
- Reset values: err_flag=0, err_code=0, all err_* fields=0, match_cnt=0, err_cnt=0, pending=0, state=RUN, FIFOs empty.
- exp_ready is combinational from the FIFO state, so it is 1 immediately after reset.
- Asserting rst_n low mid-stream clears everything asynchronously. In-flight records are discarded.

## Configuration
- WB_SB_TIMEOUT_EN defined:
  - A 16-bit idle counter counts cycles in which some pending bit is set and no act_valid bit is set.
  - Any act_valid, or all FIFOs empty, clears the counter.
  - When the counter reaches TIMEOUT, a timeout error (code 3) is raised. err_ch is the lowest pending channel, err_pc is its head PC, and err_act_* are 0. The counter then clears.
- Undefined: no counter logic, and code 3 is never produced.

## Test plan
- Push ch0 {pc=0x100, reg=3, data=0x5, mask=all-ones}, then act_valid[0] with reg=3, data=0x5 → match_cnt=1, err_flag=0, pending=0.
- Push ch0 with data=0x000012345, mask=0x00003FFFF; actual data=0xFFFC12345 → match (upper bits are ignored).
- HALT_ON_ERR=1: push ch1 {pc=0x200, reg=7, data=0xA}; actual reg=7, data=0xB → err_code=1, err_ch=1, err_pc=0x200, err_exp_data=0xA, err_act_data=0xB, exp_ready=0 thereafter.
- act_valid[0] with an empty FIFO → err_code=2, err_cnt=1, pending unchanged.
- Push DEPTH=8 records to ch0 → exp_ready=0 after the 8th. A same-cycle push and pop on the full channel: the push is not accepted, and the pop is compared.
- With WB_SB_TIMEOUT_EN and TIMEOUT=16: push one record, no actuals → err_code=3 raised at idle cycle 16. rst_n low then → all outputs 0 asynchronously.
